// File: rtl/fir_requant.sv
// fir_requant: scales 16-bit FIR sums to 8 bits with saturation, behind a small FWFT FIFO.
// Build option: define FIR_REQUANT_ROUND_EN for round-half-up before the shift (default: truncate).
module fir_requant #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       shift_amt,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sat_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [16:0]      w_q;
    logic             w_sat;
    logic             w_accept;
    logic             w_write;
    logic             w_read;
    logic [AW+1:0]    w_credit;

    logic             r_s1_valid;
    logic [7:0]       r_s1_data;
    logic             r_s1_sat;
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_sat_count;

`ifdef FIR_REQUANT_ROUND_EN
    logic [16:0] w_round;

    always_comb begin
        w_round = '0;
        if (shift_amt != 4'd0)
            w_round = 17'd1 << (shift_amt - 4'd1);
    end

    assign w_q = ({1'b0, in_data} + w_round) >> shift_amt;
`else
    assign w_q = {1'b0, in_data} >> shift_amt;
`endif

    assign w_sat = (w_q > 17'd255);

    // The stage-1 sample already owns a FIFO slot, so it is counted against capacity.
    assign w_credit  = {1'b0, r_count} + {{(AW+1){1'b0}}, r_s1_valid};
    assign in_ready  = rst & (w_credit < (AW+2)'(DEPTH));
    assign w_accept  = in_valid & in_ready;
    assign w_write   = r_s1_valid;
    assign out_valid = (r_count != '0);
    assign w_read    = out_valid & out_ready;
    assign out_data  = r_mem[r_rd_ptr];
    assign sat_count = r_sat_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_sat   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_sat ? 8'hFF : w_q[7:0];
                r_s1_sat  <= w_sat;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_mem[gi] <= '0;
                else if (w_write && (r_wr_ptr == AW'(gi)))
                    r_mem[gi] <= r_s1_data;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_read)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sat_count <= '0;
        else if (w_write && r_s1_sat && (r_sat_count != {CNT_W{1'b1}}))
            r_sat_count <= r_sat_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_fir_requant.sv
// Directed and random checks for fir_requant, built with DEPTH=4 and a 2-bit saturation counter.
module tb_fir_requant;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       shift_amt = '0;
    logic [15:0]      in_data = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic [CNT_W-1:0] sat_count;

    fir_requant #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .shift_amt(shift_amt), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [16:0] model_q(input logic [15:0] d, input logic [3:0] s);
        logic [16:0] q;
`ifdef FIR_REQUANT_ROUND_EN
        if (s != 4'd0) q = ({1'b0, d} + (17'd1 << (s - 4'd1))) >> s;
        else           q = {1'b0, d};
`else
        q = {1'b0, d} >> s;
`endif
        return q;
    endfunction

    function automatic logic [7:0] model_data(input logic [15:0] d, input logic [3:0] s);
        logic [16:0] q;
        q = model_q(d, s);
        return (q > 17'd255) ? 8'hFF : q[7:0];
    endfunction

    function automatic bit model_sat(input logic [15:0] d, input logic [3:0] s);
        return model_q(d, s) > 17'd255;
    endfunction

    // Scoreboard: expected outputs enter at accept and leave at read.
    logic [7:0]       exp_q[$];
    int               n_acc = 0;
    logic [CNT_W-1:0] exp_sat = '0;

    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            exp_sat <= '0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("pop_when_empty", 32'd1, 32'd0);
                else                   check("stream_order", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_data(in_data, shift_amt));
                n_acc <= n_acc + 1;
                if (model_sat(in_data, shift_amt) && exp_sat != {CNT_W{1'b1}})
                    exp_sat <= exp_sat + 1'b1;
            end
        end
    end

    task automatic drive(input logic [15:0] d, input logic [3:0] s);
        logic acc;
        int budget;
        in_valid  = 1'b1;
        in_data   = d;
        shift_amt = s;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic send_and_check(input string tag, input logic [15:0] d, input logic [7:0] exp);
        drive(d, 4'd4);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_valid"}, out_valid, 32'd1);
        check({tag, "_data"}, out_data, exp);
    endtask

    bit rnd_done = 0;
    int acc_base;

    initial begin
        // Reset held with valid input asserted
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 32'd0);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_sat_count", sat_count, 32'd0);
        check("rst_no_accept", n_acc, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("release_in_ready", in_ready, 32'd1);
        @(posedge clk);
        #1;

        // Latency, rounding, saturation
        out_ready = 1'b1;
        send_and_check("lat_0123", 16'h0123, 8'h12);
`ifdef FIR_REQUANT_ROUND_EN
        send_and_check("round_0128", 16'h0128, 8'h13);
`else
        send_and_check("round_0128", 16'h0128, 8'h12);
`endif
        send_and_check("sat_0ff8", 16'h0FF8, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
`ifdef FIR_REQUANT_ROUND_EN
        check("sat_count_after_0ff8", sat_count, 32'd1);
`else
        check("sat_count_after_0ff8", sat_count, 32'd0);
`endif

        // Backpressure: four accepted, then stall
        out_ready = 1'b0;
        acc_base  = n_acc;
        for (int i = 1; i <= 4; i++) drive(16'(i), 4'd0);
        in_valid = 1'b1;
        in_data  = 16'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 32'd0);
        end
        check("bp_accepted", n_acc - acc_base, 32'd4);
        check("bp_head", out_data, 32'd1);
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) drive(16'(i), 4'd0);
        in_valid = 1'b0;
        drain();
        check("bp_total", n_acc - acc_base, 32'd8);

        // Random streaming with random consumer stalls
        acc_base = n_acc;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    drive(16'($urandom), 4'($urandom_range(0, 15)));
                end
                in_valid = 1'b0;
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("rnd_accepted", n_acc - acc_base, 32'd100);
        @(posedge clk);
        #1;
        check("rnd_sat_count", sat_count, exp_sat);

        // Counter limit: 5 more saturating samples pin the 2-bit counter
        for (int i = 0; i < 5; i++) drive(16'hFFFF, 4'd0);
        in_valid = 1'b0;
        drain();
        @(posedge clk);
        #1;
        check("sat_count_pinned", sat_count, 32'd3);

        // Asynchronous reset mid-burst
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(16'(8'hA0 + i), 4'd0);
        check("burst_valid", out_valid, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 32'd0);
        check("arst_out_valid", out_valid, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_sat_count", sat_count, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_out_valid", out_valid, 32'd0);
        check("post_rst_in_ready", in_ready, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fir_requant.md
# fir_requant

Output requantizer and elastic buffer that sits directly downstream of the FIR filter. It accepts 16-bit unsigned filter sums over a valid/ready handshake and scales each sum by a programmable right shift. Results above 255 saturate to 8 bits. Results are buffered in a small FIFO so the FIR pipeline keeps streaming while the 8-bit consumer stalls. A saturation event counter is exposed for debug.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CNT_W, 16: width of the saturation counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting it (rst=0) resets all state immediately.
- shift_amt  input  4  right-shift amount 0..15; sampled together with each accepted input.
- in_data  input  16  unsigned FIR sum, driven from the FIR output_data.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block can accept a sample this cycle.
- out_data  output  8  requantized sample at the FIFO head.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- sat_count  output  CNT_W  number of saturated samples; sticks at all-ones.

## Operation
- Accept: occurs when in_valid & in_ready at a rising edge.
- Stage 1 computes q in 17 bits and stores it in a single pipeline register (s1_valid, s1_data[7:0], s1_sat):
  - Without rounding: q = in_data >> shift_amt.
  - With rounding and shift_amt > 0: q = (in_data + (1 << (shift_amt-1))) >> shift_amt.
  - Saturation: if q > 255, s1_data = 255 and s1_sat = 1; otherwise s1_data = q[7:0].
- Stage 2 writes s1_data into the FIFO on the edge after the accept and clears s1_valid, unless a new accept reloads it. On that same edge, sat_count increments if s1_sat is set.
- FIFO: write and read pointers of log2(DEPTH) bits wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits.
- Read: occurs when out_valid & out_ready. The read pointer advances.
- out_valid = (count != 0). out_data = mem[rd_ptr], first-word fall-through.
- Credit rule: in_ready = rst & ((count + s1_valid) < DEPTH). This reserves a slot for the sample held in stage 1, so the FIFO never overflows and no sample is dropped.
- Simultaneous FIFO write and read: count is unchanged and both pointers advance. This holds when full and also at count 1.
- Read while empty is impossible because out_valid = 0. Reads only pop the head; the pending stage-1 write lands at the tail.
- sat_count saturates at 2^CNT_W-1 and never wraps.

## Timing
- Latency: a sample accepted at edge k appears as out_valid = 1 with its data after edge k+1, provided the FIFO was empty.
- Throughput: one sample per cycle while out_ready = 1.
- in_ready is combinational from registered state only. It has no path from in_valid or out_ready.
- Reset values, applied asynchronously when rst=0:
  - in_ready=0, out_valid=0, out_data=0, sat_count=0.
  - Pointers, count and s1_valid are 0. FIFO memory is cleared to 0.
- Reset mid-operation: everything in flight is discarded, including the stage-1 sample and all FIFO contents.
- First accept after reset release: in_ready rises in the same cycle that rst goes high. The first accept is possible at the first rising edge after release.
- in_data and shift_amt are don't-care when in_valid=0.
- out_data is don't-care when out_valid=0, except immediately after reset.

## Configuration
- Macro FIR_REQUANT_ROUND_EN controls rounding.
- Defined: the round-half-up offset is added before the shift, and saturation applies after rounding.
- Undefined: plain truncation, with no adder in stage 1.
- shift_amt=0 is an identity shift in both builds.

## Test plan
- Reset check: hold rst=0 with in_valid=1. Expect in_ready=0, out_valid=0, out_data=0, sat_count=0, and nothing accepted.
- Latency and rounding (shift_amt=4, out_ready=1):
  - in_data=0x0123: out_data=0x12 after 2 edges, in both builds.
  - in_data=0x0128: out_data=0x13 with ROUND_EN, 0x12 without.
- Saturation (shift_amt=4): in_data=0x0FF8 gives out_data=0xFF. With ROUND_EN, sat_count goes from 0 to 1. Without it, q=0xFF is not saturated and sat_count stays 0.
- Backpressure (DEPTH=4, out_ready=0, continuous valid inputs 1..8, shift_amt=0):
  - Exactly 4 samples are accepted and in_ready drops to 0.
  - Raising out_ready drains 1,2,3,4 in order, followed by 5..8 with no loss or duplication.
- Full-rate streaming with simultaneous read and write: 100 random samples with random out_ready toggling; output must match the model in order.
- Counter limit and async reset (CNT_W=2): 5 saturating samples leave sat_count=3. Asserting rst mid-burst clears all outputs immediately, without a clock edge.
